// File: rtl/song_pkg.sv
// Shared types and constants for the song sequencer and note player.
// ROM entry layout is {note[11:6], duration[5:0]}; note 0 is a rest.
package song_pkg;

    localparam int NOTE_W  = 6;
    localparam int DUR_W   = 6;
    localparam int ENTRY_W = 12;

    localparam logic [NOTE_W-1:0] NOTE_REST = '0;

    localparam int NOTE_MSB = 11;
    localparam int NOTE_LSB = 6;
    localparam int DUR_MSB  = 5;
    localparam int DUR_LSB  = 0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT,
        S_LOAD,
        S_PLAY,
        S_DONE
    } song_seq_state_t;

    function automatic logic [NOTE_W-1:0] entry_note(input logic [ENTRY_W-1:0] entry);
        return entry[NOTE_MSB:NOTE_LSB];
    endfunction

    function automatic logic [DUR_W-1:0] entry_dur(input logic [ENTRY_W-1:0] entry);
        return entry[DUR_MSB:DUR_LSB];
    endfunction

endpackage

// File: rtl/song_seq_ctrl_if.sv
// Control, ROM and note-player signals of the song sequencer.
// The sequencer takes the slave modport; the environment takes master.
interface song_seq_ctrl_if #(
    parameter int SONG_BITS = 2,
    parameter int IDX_BITS  = 5
);
    import song_pkg::*;

    logic                          play;
    logic                          restart;
    logic [SONG_BITS-1:0]          song_sel;
    logic                          beat;
    logic [SONG_BITS+IDX_BITS-1:0] rom_addr;
    logic [ENTRY_W-1:0]            rom_dout;
    logic [NOTE_W-1:0]             note;
    logic                          new_note;
    logic                          playing;
    logic                          song_done;

    modport slave (
        input  play, restart, song_sel, beat, rom_dout,
        output rom_addr, note, new_note, playing, song_done
    );

    modport master (
        output play, restart, song_sel, beat, rom_dout,
        input  rom_addr, note, new_note, playing, song_done
    );

endinterface

// File: rtl/song_dur_counter.sv
// Note-duration counter: loads a duration, counts it down on beats while
// running, and flags the final beat (cnt = 1). Shared with the note player.
module song_dur_counter
    import song_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             clear_i,
    input  logic             load_i,
    input  logic [DUR_W-1:0] load_val_i,
    input  logic             beat_i,
    input  logic             run_i,
    output logic             last_o
);

    logic [DUR_W-1:0] cnt_q, cnt_d;

    // NOTE: cnt_d takes its hold value first, so no path through this block can infer a latch.
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (load_i) begin
            cnt_d = load_val_i;
        end else if (run_i && beat_i && (cnt_q > DUR_W'(1))) begin
            cnt_d = cnt_q - DUR_W'(1);
        end
    end

    // NOTE: registers update with <= so every flop samples the pre-edge value of its inputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign last_o = (cnt_q == DUR_W'(1));

endmodule

// File: rtl/song_seq_ctrl.sv
// Song sequencer: walks one song of the song ROM, absorbs its 1-cycle read latency,
// strobes each note to the player and times it in beats. Optional: SONG_SEQ_NOTE_GAP_EN.
module song_seq_ctrl
    import song_pkg::*;
#(
    parameter int SONG_BITS = 2,
    parameter int IDX_BITS  = 5
) (
    input logic             clk,
    input logic             reset,
    song_seq_ctrl_if.slave  bus
);

    localparam int ADDR_W = SONG_BITS + IDX_BITS;
    localparam logic [IDX_BITS-1:0] IDX_LAST = '1;

    song_seq_state_t      state_q,    state_d;
    logic [SONG_BITS-1:0] cur_song_q, cur_song_d;
    logic [IDX_BITS-1:0]  idx_q,      idx_d;
    logic [ADDR_W-1:0]    rom_addr_q, rom_addr_d;
    logic [NOTE_W-1:0]    note_q,     note_d;
    logic                 new_note_q, new_note_d;
    logic                 playing_q,  playing_d;
    logic                 done_q,     done_d;
    logic                 armed_q,    armed_d;

    logic [NOTE_W-1:0] rom_note;
    logic [DUR_W-1:0]  rom_dur;
    logic              load_note;
    logic              play_run;
    logic              cnt_last;
    logic              note_expire;

    assign rom_note    = entry_note(bus.rom_dout);
    assign rom_dur     = entry_dur(bus.rom_dout);
    assign load_note   = (state_q == S_LOAD) && (rom_dur != '0);
    assign play_run    = (state_q == S_PLAY) && bus.play;
    assign note_expire = play_run && bus.beat && cnt_last;

    song_dur_counter u_dur (
        .clk        (clk),
        .reset      (reset),
        .clear_i    (bus.restart),
        .load_i     (load_note),
        .load_val_i (rom_dur),
        .beat_i     (bus.beat),
        .run_i      (play_run),
        .last_o     (cnt_last)
    );

    always_comb begin
        state_d    = state_q;
        cur_song_d = cur_song_q;
        idx_d      = idx_q;
        rom_addr_d = rom_addr_q;
        note_d     = note_q;
        new_note_d = 1'b0;
        done_d     = 1'b0;
        armed_d    = armed_q;

        // A finished song only replays after play has been seen low again.
        if (!bus.play) begin
            armed_d = 1'b1;
        end else if (state_q == S_DONE) begin
            armed_d = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                cur_song_d = bus.song_sel;
                idx_d      = '0;
                note_d     = NOTE_REST;
                if (bus.play && armed_q) begin
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                rom_addr_d = {cur_song_q, idx_q};
                state_d    = S_WAIT;
            end
            S_WAIT: begin
                state_d = S_LOAD;
            end
            S_LOAD: begin
                if (rom_dur == '0) begin
                    note_d  = NOTE_REST;
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end else begin
                    note_d     = rom_note;
                    new_note_d = 1'b1;
                    state_d    = S_PLAY;
                end
            end
            S_PLAY: begin
                // The old note keeps sounding through FETCH/WAIT of the next entry.
                if (note_expire) begin
                    if (idx_q == IDX_LAST) begin
                        note_d  = NOTE_REST;
                        done_d  = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        idx_d   = idx_q + IDX_BITS'(1);
                        state_d = S_FETCH;
                    end
                end
            end
            S_DONE: begin
                note_d  = NOTE_REST;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (bus.restart) begin
            cur_song_d = bus.song_sel;
            idx_d      = '0;
            note_d     = NOTE_REST;
            new_note_d = 1'b0;
            done_d     = 1'b0;
            state_d    = bus.play ? S_FETCH : S_IDLE;
        end

        playing_d = (state_d == S_PLAY) && bus.play;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            cur_song_q <= '0;
            idx_q      <= '0;
            rom_addr_q <= '0;
            note_q     <= NOTE_REST;
            new_note_q <= 1'b0;
            playing_q  <= 1'b0;
            done_q     <= 1'b0;
            armed_q    <= 1'b1;
        end else begin
            state_q    <= state_d;
            cur_song_q <= cur_song_d;
            idx_q      <= idx_d;
            rom_addr_q <= rom_addr_d;
            note_q     <= note_d;
            new_note_q <= new_note_d;
            playing_q  <= playing_d;
            done_q     <= done_d;
            armed_q    <= armed_d;
        end
    end

    assign bus.rom_addr  = rom_addr_q;
    assign bus.new_note  = new_note_q;
    assign bus.playing   = playing_q;
    assign bus.song_done = done_q;

`ifdef SONG_SEQ_NOTE_GAP_EN
    // Silence the last beat of each note so repeated notes re-articulate.
    assign bus.note = ((state_q == S_PLAY) && cnt_last) ? NOTE_REST : note_q;
`else
    assign bus.note = note_q;
`endif

endmodule
